// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the beta CPU multi-cycle control path: FSM states,
// opcode/funct constants, PC source selects and small opcode classifiers.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b000001;
  localparam logic [5:0] OP_SW    = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b000011;
  localparam logic [5:0] OP_SUBI  = 6'b000100;
  localparam logic [5:0] OP_BEQ   = 6'b000111;
  localparam logic [5:0] OP_BNE   = 6'b001000;

  localparam logic [5:0] FUNCT_JR   = 6'b010100;
  localparam logic [5:0] FUNCT_JALR = 6'b010101;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_REG    = 2'b10;

  function automatic logic op_defined(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_BEQ, OP_BNE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Opcodes whose second ALU operand is the sign-extended immediate.
  function automatic logic op_uses_imm(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW, OP_ADDI, OP_SUBI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_multicycle_control_if.sv
// Unified instruction/data memory handshake between the control FSM
// (master) and the memory port (slave).
interface cpu_multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/cpu_mem_watchdog.sv
// Memory-stall watchdog: counts consecutive unanswered request cycles,
// flags expiry combinationally and keeps a sticky bus_error.
module cpu_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req,
  input  logic ready,
  input  logic restart,
  output logic expired,
  output logic bus_error
);

  logic [CNT_W-1:0] cnt;

  // A ready in the expiry cycle completes the access and suppresses the error.
  assign expired = req && !ready && (cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      bus_error <= 1'b0;
    end else begin
      if (ready || restart || !req)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (expired)
        bus_error <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_multicycle_control.sv
// Multi-cycle main control FSM for the beta CPU core (Mealy output decode).
// Optional performance counters are enabled with `define CPU_CTRL_PERF_EN.
module cpu_multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_cond,
  cpu_multicycle_control_if.master mem,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        link_write,
  output logic        illegal_op,
  output logic        bus_error,
  output logic [2:0]  state
`ifdef CPU_CTRL_PERF_EN
  , output logic [31:0] retired
  , output logic [31:0] stall_cycles
`endif
);

  state_t cur_state, next_state;
  logic   wd_expired;
  logic   state_change;
  logic   is_jump_reg;
  logic   is_jalr;

  assign is_jump_reg  = (opcode == OP_RTYPE) && (funct[5:1] == FUNCT_JR[5:1]);
  assign is_jalr      = (opcode == OP_RTYPE) && (funct == FUNCT_JALR);
  assign state_change = (next_state != cur_state);
  assign state        = cur_state;

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_RST:    next_state = ST_FETCH;
      ST_FETCH: begin
        if (mem.mem_ready)   next_state = ST_DECODE;
        else if (wd_expired) next_state = ST_HALT;
      end
      ST_DECODE: next_state = op_defined(opcode) ? ST_EXEC : ST_FETCH;
      ST_EXEC: begin
        if (is_jump_reg)
          next_state = ST_FETCH;
        else begin
          case (opcode)
            OP_BEQ, OP_BNE: next_state = ST_FETCH;
            OP_LW, OP_SW:   next_state = ST_MEM;
            default:        next_state = ST_WB;
          endcase
        end
      end
      ST_MEM: begin
        if (mem.mem_ready)   next_state = (opcode == OP_SW) ? ST_FETCH : ST_WB;
        else if (wd_expired) next_state = ST_HALT;
      end
      ST_WB:     next_state = ST_FETCH;
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_RST;
    endcase
  end

  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_SEQ;
    alu_src_b   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    link_write  = 1'b0;
    illegal_op  = 1'b0;
    case (cur_state)
      ST_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      ST_DECODE: illegal_op = !op_defined(opcode);
      ST_EXEC: begin
        alu_src_b = op_uses_imm(opcode);
        if (is_jump_reg) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_REG;
          if (is_jalr) begin
            link_write = 1'b1;
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
          end
        end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
          pc_write = alu_cond;
          pc_src   = PC_SRC_BRANCH;
        end
      end
      ST_MEM: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        mem.mem_we  = (opcode == OP_SW);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        mem_to_reg = (opcode == OP_LW);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cur_state <= ST_RST;
    else          cur_state <= next_state;
  end

  cpu_mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_watchdog (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (mem.mem_req),
    .ready     (mem.mem_ready),
    .restart   (state_change),
    .expired   (wd_expired),
    .bus_error (bus_error)
  );

`ifdef CPU_CTRL_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      if (next_state == ST_FETCH &&
          (cur_state == ST_EXEC || cur_state == ST_MEM || cur_state == ST_WB))
        retired <= retired + 32'd1;
      if (mem.mem_req && !mem.mem_ready)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_multicycle_control.sv
// Self-checking bench for cpu_multicycle_control: instruction table with a
// scoreboard queue, plus hand-written stall, watchdog and reset sequences.
module tb_cpu_multicycle_control;
  import cpu_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_cond = 1'b0;
  logic       ir_write, pc_write, alu_src_b, reg_write, reg_dst;
  logic       mem_to_reg, link_write, illegal_op, bus_error;
  logic [1:0] pc_src;
  logic [2:0] state;
`ifdef CPU_CTRL_PERF_EN
  logic [31:0] retired, stall_cycles;
`endif

  cpu_multicycle_control_if bus();

  cpu_multicycle_control #(
    .MEM_TIMEOUT (15),
    .CNT_W       (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .alu_cond   (alu_cond),
    .mem        (bus),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .link_write (link_write),
    .illegal_op (illegal_op),
    .bus_error  (bus_error),
    .state      (state)
`ifdef CPU_CTRL_PERF_EN
    , .retired      (retired)
    , .stall_cycles (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        cond;
    logic [31:0] trace;      // one nibble per cycle, FETCH first
    logic [6:0]  exec_bits;  // {pc_write, pc_src, alu_src_b, link_write, reg_write, reg_dst}
    logic [2:0]  mem_bits;   // {mem_req, iord, mem_we}
    logic [2:0]  wb_bits;    // {reg_write, reg_dst, mem_to_reg}
    int unsigned n_regw;
    int unsigned n_illegal;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[12];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [5:0] op, input logic [5:0] fn,
                              input logic c, input logic [31:0] tr, input logic [6:0] eb,
                              input logic [2:0] mb, input logic [2:0] wb,
                              input int unsigned nr, input int unsigned ni);
    vec_t v;
    v.name = n; v.op = op; v.fn = fn; v.cond = c; v.trace = tr;
    v.exec_bits = eb; v.mem_bits = mb; v.wb_bits = wb; v.n_regw = nr; v.n_illegal = ni;
    return v;
  endfunction

  // Entered at posedge+#1 of a FETCH cycle; leaves at posedge+#1 of the next FETCH.
  task automatic run_vec(input vec_t v);
    vec_t obs;
    vec_t exp;
    bit   done = 1'b0;
    obs = v;
    obs.trace = '0; obs.exec_bits = '0; obs.mem_bits = '0; obs.wb_bits = '0;
    obs.n_regw = 0; obs.n_illegal = 0;
    opcode = v.op; funct = v.fn; alu_cond = v.cond; bus.mem_ready = 1'b1;
    sb.push_back(v);
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clock);
      obs.trace = {obs.trace[27:0], 1'b0, state};
      if (reg_write)  obs.n_regw++;
      if (illegal_op) obs.n_illegal++;
      case (state)
        ST_FETCH:  check({v.name, ".fetch"},
                         32'({bus.mem_req, bus.iord, bus.mem_we, ir_write, pc_write, pc_src}),
                         32'(7'b1001100));
        ST_DECODE: check({v.name, ".decode_quiet"},
                         32'({bus.mem_req, bus.mem_we, bus.iord, ir_write, pc_write, pc_src,
                              alu_src_b, reg_write, reg_dst, mem_to_reg, link_write}), 32'd0);
        ST_EXEC:   obs.exec_bits = {pc_write, pc_src, alu_src_b, link_write, reg_write, reg_dst};
        ST_MEM:    obs.mem_bits  = {bus.mem_req, bus.iord, bus.mem_we};
        ST_WB:     obs.wb_bits   = {reg_write, reg_dst, mem_to_reg};
        default: ;
      endcase
      @(posedge clock); #1;
      if (state == ST_FETCH) done = 1'b1;
    end
    exp = sb.pop_front();
    check({exp.name, ".done"},    32'(done), 32'd1);
    check({exp.name, ".trace"},   obs.trace, exp.trace);
    check({exp.name, ".exec"},    32'(obs.exec_bits), 32'(exp.exec_bits));
    check({exp.name, ".mem"},     32'(obs.mem_bits), 32'(exp.mem_bits));
    check({exp.name, ".wb"},      32'(obs.wb_bits), 32'(exp.wb_bits));
    check({exp.name, ".n_regw"},  obs.n_regw, exp.n_regw);
    check({exp.name, ".illegal"}, obs.n_illegal, exp.n_illegal);
  endtask

  task automatic wait_state(input logic [2:0] target, input int unsigned bound, input string name);
    bit hit = 1'b0;
    for (int unsigned i = 0; i < bound && !hit; i++) begin
      @(posedge clock); #1;
      if (state == target) hit = 1'b1;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int unsigned memc, mem_ok, wb_ok, fc;
    bit          done, err_seen;

    vecs[0]  = mk("add",  OP_RTYPE, 6'b100000, 1'b0, 32'h1235,  7'b0000000, 3'b000, 3'b110, 1, 0);
    vecs[1]  = mk("lw",   OP_LW,    6'b000000, 1'b0, 32'h12345, 7'b0001000, 3'b110, 3'b101, 1, 0);
    vecs[2]  = mk("sw",   OP_SW,    6'b000000, 1'b0, 32'h1234,  7'b0001000, 3'b111, 3'b000, 0, 0);
    vecs[3]  = mk("addi", OP_ADDI,  6'b000000, 1'b0, 32'h1235,  7'b0001000, 3'b000, 3'b100, 1, 0);
    vecs[4]  = mk("subi", OP_SUBI,  6'b111111, 1'b1, 32'h1235,  7'b0001000, 3'b000, 3'b100, 1, 0);
    vecs[5]  = mk("beq1", OP_BEQ,   6'b000000, 1'b1, 32'h123,   7'b1010000, 3'b000, 3'b000, 0, 0);
    vecs[6]  = mk("beq0", OP_BEQ,   6'b000000, 1'b0, 32'h123,   7'b0010000, 3'b000, 3'b000, 0, 0);
    vecs[7]  = mk("bne1", OP_BNE,   6'b000000, 1'b1, 32'h123,   7'b1010000, 3'b000, 3'b000, 0, 0);
    vecs[8]  = mk("jr",   OP_RTYPE, 6'b010100, 1'b0, 32'h123,   7'b1100000, 3'b000, 3'b000, 0, 0);
    vecs[9]  = mk("jalr", OP_RTYPE, 6'b010101, 1'b0, 32'h123,   7'b1100111, 3'b000, 3'b000, 1, 0);
    vecs[10] = mk("ill3e", 6'b111110, 6'b000000, 1'b0, 32'h12,  7'b0000000, 3'b000, 3'b000, 0, 1);
    vecs[11] = mk("ill05", 6'b000101, 6'b000000, 1'b0, 32'h12,  7'b0000000, 3'b000, 3'b000, 0, 1);

    bus.mem_ready = 1'b1;

    // Reset state and first transition
    @(negedge clock);
    check("rst.state", 32'(state), 32'd0);
    check("rst.outputs",
          32'({bus.mem_req, bus.mem_we, bus.iord, ir_write, pc_write, pc_src, alu_src_b,
               reg_write, reg_dst, mem_to_reg, link_write, illegal_op, bus_error}), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst.exit_fetch", 32'(state), 32'(ST_FETCH));

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // lw with three wait cycles in MEM
    opcode = OP_LW; funct = '0; bus.mem_ready = 1'b1;
    memc = 0; mem_ok = 0; wb_ok = 0; done = 1'b0; err_seen = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      if (state == ST_MEM && bus.mem_req && bus.iord && !bus.mem_we) mem_ok++;
      if (state == ST_WB && reg_write && mem_to_reg) wb_ok++;
      err_seen |= bus_error;
      @(posedge clock); #1;
      if (state == ST_MEM) begin
        memc++;
        bus.mem_ready = (memc >= 4);
      end else
        bus.mem_ready = 1'b1;
      if (state == ST_FETCH) done = 1'b1;
    end
    check("lw_stall.done",    32'(done), 32'd1);
    check("lw_stall.mem_cyc", mem_ok, 32'd4);
    check("lw_stall.wb",      wb_ok, 32'd1);
    check("lw_stall.no_err",  32'(err_seen), 32'd0);

    // mem_ready arrives in the expiry cycle: access completes, no error
    opcode = OP_ADDI; bus.mem_ready = 1'b0; fc = 1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (state != ST_FETCH) break;
      fc++;
      if (fc == 16) bus.mem_ready = 1'b1;
    end
    check("wd_edge.fetch_cyc", fc, 32'd16);
    check("wd_edge.state",     32'(state), 32'(ST_DECODE));
    check("wd_edge.no_err",    32'(bus_error), 32'd0);
    bus.mem_ready = 1'b1;
    wait_state(ST_FETCH, 6, "wd_edge.back_to_fetch");

    // Reset asserted mid-access drops mem_req without a clock edge
    bus.mem_ready = 1'b0;
    @(negedge clock);
    check("midrst.req_before", 32'(bus.mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst.req_dropped", 32'(bus.mem_req), 32'd0);
    check("midrst.state",       32'(state), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("midrst.exit_fetch", 32'(state), 32'(ST_FETCH));

    // Watchdog expiry from a FETCH stuck without mem_ready
    fc = 1; err_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      err_seen |= bus_error;
      @(posedge clock); #1;
      if (state != ST_FETCH) break;
      fc++;
    end
    check("wd.fetch_cyc",   fc, 32'd16);
    check("wd.pre_err",     32'(err_seen), 32'd0);
    check("wd.halt_state",  32'(state), 32'(ST_HALT));
    check("wd.bus_error",   32'(bus_error), 32'd1);

    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("halt.state_held", 32'(state), 32'(ST_HALT));
    check("halt.quiet",
          32'({bus.mem_req, bus.mem_we, bus.iord, ir_write, pc_write, pc_src, alu_src_b,
               reg_write, reg_dst, mem_to_reg, link_write, illegal_op}), 32'd0);
    check("halt.err_sticky", 32'(bus_error), 32'd1);

    reset_n = 1'b0;
    #1;
    check("halt_rst.state", 32'(state), 32'd0);
    check("halt_rst.err",   32'(bus_error), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("halt_rst.exit_fetch", 32'(state), 32'(ST_FETCH));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_multicycle_control.md
Name: cpu_multicycle_control

Overview:
- Multi-cycle main control FSM for the beta CPU core.
- Sequences fetch, decode, execute, memory and writeback around the shared ALU and the unified instruction/data memory port.
- Decodes the same opcode/funct space that the ALU control decoder consumes.
- Owns the memory handshake, a memory-stall watchdog and the halt condition.

Parameters:
- MEM_TIMEOUT, 15: max consecutive cycles mem_req may wait for mem_ready before bus error (1..255).
- CNT_W, 8: width of internal watchdog counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- alu_cond  in  1  ALU compare result (1 = branch condition true for beq/bne function codes)
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualifies mem_req
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  00 = PC+1, 01 = branch target, 10 = register (jr/jalr)
- alu_src_b  out  1  0 = register rt, 1 = sign-extended immediate
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  writeback source: 0 = ALU, 1 = memory data
- link_write  out  1  write PC into rd (jalr)
- illegal_op  out  1  one-cycle pulse on undefined opcode
- bus_error  out  1  sticky; set on watchdog expiry
- state  out  3  current FSM state, for debug

Behaviour:
- Reset: asynchronous on reset_n low → state RST, counter 0, bus_error 0. All outputs 0 while in RST. RST → FETCH unconditionally on the first clock after release.
- Encoding: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7. Outputs are decoded from state and inputs (Mealy on mem_ready and alu_cond).
- FETCH:
  - mem_req=1, iord=0, mem_we=0.
  - When mem_ready=1 in the same cycle: ir_write=1, pc_write=1, pc_src=00 → DECODE. Otherwise stay.
- DECODE: one cycle, no strobes.
  - Defined opcodes 000000, 000001, 000010, 000011, 000100, 000111, 001000 → EXEC.
  - Any other opcode: illegal_op=1 for this cycle → FETCH.
- EXEC:
  - alu_src_b=1 for opcodes 000001/000010/000011/000100; 0 otherwise.
  - r-type with funct[5:1]=01010 (jr/jalr):
    - pc_write=1, pc_src=10.
    - jalr (funct 010101) additionally: link_write=1, reg_write=1, reg_dst=1.
    - → FETCH.
  - beq/bne: pc_write=alu_cond, pc_src=01 → FETCH.
  - lw/sw → MEM.
  - Other r-type, addi, subi → WB.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for sw only.
  - On mem_ready: sw → FETCH; lw → WB.
- WB:
  - reg_write=1.
  - reg_dst=1 for r-type, 0 otherwise.
  - mem_to_reg=1 for lw only.
  - → FETCH.
- Zero-wait latency (clock cycles per instruction):
  - r-type/addi/subi: 4.
  - lw: 5.
  - sw: 4.
  - beq/bne/jr/jalr: 3.
- Watchdog:
  - Counter increments each cycle mem_req=1 and mem_ready=0.
  - Clears on mem_ready or any state change.
  - When the counter equals MEM_TIMEOUT with mem_ready still 0: → HALT, bus_error=1.
  - mem_ready in the expiry cycle wins; the access completes and there is no error.
- HALT: all strobes 0, bus_error held; exit only via reset_n.
- reset_n asserted mid-access: mem_req drops immediately (asynchronous); the access is abandoned.
- opcode/funct are not registered by this block; the IR must hold them stable from DECODE through WB.

Optional Feature:
- CPU_CTRL_PERF_EN defined:
  - Adds output retired (32 bit) and output stall_cycles (32 bit); both reset to 0.
  - retired increments on every transition into FETCH from EXEC/MEM/WB.
  - stall_cycles increments each cycle mem_req=1 and mem_ready=0.
  - Both wrap at 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding constants;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_BEQ, OP_BNE);
  - FUNCT_JR=010100, FUNCT_JALR=010101;
  - pc_src encodings.
- One natural sub-module: cpu_mem_watchdog (counter, compare, expiry flag). The FSM and output decode stay in the top module.

Test Plan:
- Reset release, opcode=000000, funct=100000, mem_ready tied 1 → states 1,2,3,5,1; reg_write=1, reg_dst=1 in exactly one cycle; 4 cycles per instruction.
- lw (000001), mem_ready low 3 cycles in MEM → mem_req=1, iord=1 held 4 cycles; then WB with mem_to_reg=1; no bus_error.
- beq (000111) with alu_cond=1, then alu_cond=0 → pc_write=1, pc_src=01 in EXEC only for the first; 3 cycles each.
- jalr (opcode 0, funct 010101) → EXEC asserts pc_write, pc_src=10, link_write, reg_write, reg_dst together; → FETCH.
- opcode 111110 → illegal_op one-cycle pulse in DECODE; next state FETCH; no other strobes.
- FETCH with mem_ready stuck 0, MEM_TIMEOUT=15:
  - bus_error=1 and state=7 after 16 cycles;
  - mem_ready=1 on cycle 16 instead → DECODE, no error;
  - reset_n pulse clears to RST.
